dff_pipe: RTL
=============

# dff_pipe

Parametrised elastic register pipeline. It generalises the single D flip-flop into a WIDTH-bit, DEPTH-stage delay line with synchronous reset and valid/ready flow control. Empty stages collapse as bubbles. The block also has a synchronous flush and an occupancy count. It sits between a producer and a consumer that both use valid/ready, wherever a fixed multi-cycle register delay must tolerate backpressure.

## Interface
- WIDTH, 8, data width in bits (≥1)
- DEPTH, 4, number of register stages (≥1)
- RESET_VAL, 0, value loaded into every stage data register on reset and flush
- clk  input  1  clock; all state updates on its rising edge
- rst_n  input  1  reset, synchronous and active-low
- flush  input  1  synchronous clear of all stages; active-high
- in_valid  input  1  producer has data on in_data
- in_data  input  WIDTH  data to enqueue
- in_ready  output  1  pipeline accepts in_data this cycle
- out_valid  output  1  out_data holds a valid item
- out_data  output  WIDTH  data of stage DEPTH-1
- out_ready  input  1  consumer takes out_data this cycle
- count  output  $clog2(DEPTH+1)  number of valid stages

## Operation
- Per-stage state: valid bit v[i] and data register d[i], for i = 0..DEPTH-1. Stage 0 is the input side. Stage DEPTH-1 drives out_valid and out_data.
- Stage DEPTH-1 moves when its content leaves: mv[DEPTH-1] = v[DEPTH-1] & out_ready.
- Stage i < DEPTH-1 can take new content when it is empty or its own content leaves: take[i] = !v[i] | mv[i].
- Stage i < DEPTH-1 moves its content forward when it is valid and the next stage can take: mv[i] = v[i] & take[i+1].
- in_ready = !flush & (!v[0] | mv[0]).
- An item is accepted when in_valid & in_ready.
- On each edge without reset or flush:
  - Stage i (i>0) loads d[i-1] and sets v[i] when mv[i-1].
  - Otherwise, stage i clears v[i] when mv[i].
  - Otherwise, stage i holds.
  - Stage 0 loads in_data and sets v[0] on accept. Otherwise it clears on mv[0]. Otherwise it holds.
- Bubble collapsing: a valid stage advances into an empty downstream stage even while out_ready is low. Items are never overwritten or dropped except by flush or reset.
- out_valid = v[DEPTH-1] & !flush. out_data = d[DEPTH-1]. While flush is high no output handshake occurs.
- Data registers of invalid stages may hold stale values. out_data is only meaningful when out_valid is high.
- count = popcount(v). It is a registered value updated on the same edge as v. In a cycle with simultaneous accept and output, count is unchanged.
- Flush: on an edge with flush=1 and rst_n=1, all v cleared and all d loaded with RESET_VAL. An item presented in the flush cycle is not accepted (in_ready=0).
- Reset priority: rst_n=0 over flush over normal operation.

## Timing
- Reset values: v=all 0, d=RESET_VAL, out_valid=0, out_data=RESET_VAL, count=0.
- in_ready after reset is 1, unless flush is high.
- Latency: an item accepted at edge T into an empty pipeline is visible on out_valid/out_data immediately after edge T+DEPTH-1. With DEPTH=1 it is visible after edge T.
- Throughput: one item per cycle when out_ready is held high, with no bubbles inserted.
- in_ready is combinational from out_ready, through the mv chain (a DEPTH-long path). out_valid and out_data are purely registered.
- Full (count=DEPTH) with out_ready=0: in_ready=0 and all stages hold.
- Full with out_ready=1: an accept in the same cycle is allowed, and count stays DEPTH.
- Empty (count=0): out_valid=0. out_ready is ignored.
- Reset or flush asserted mid-stream: all in-flight items are discarded at that edge. The next accepted item sees the full DEPTH latency.
- DEPTH=1 degenerates to a single-entry register slice with in_ready = !v[0] | out_ready.

## Test plan
All scenarios use WIDTH=8, DEPTH=4, RESET_VAL=8'hA5.
- **Reset:** rst_n=0 for 2 edges with in_valid=1 → out_valid=0, out_data=8'hA5, count=0. in_ready=1 on the first cycle after release.
- **Streaming:** out_ready=1, send 8'h01..8'h08 on consecutive cycles → 8'h01 appears 3 edges after its accept edge. Items then follow one per cycle, in order, with no gaps. count peaks at 4.
- **Backpressure fill:** out_ready=0, send 8'h10,8'h11,8'h12,8'h13,8'h14 → first four accepted, in_ready=0 on the fifth, count=4, out_data=8'h10.
  - Then raise out_ready for 1 cycle → 8'h10 consumed, 8'h14 accepted the same cycle, count stays 4.
- **Bubble collapse:** with out_ready=0, send 8'h20, idle 2 cycles, send 8'h21 → both items are packed into stages 3 and 2 with no gap. count=2.
- **Flush mid-stream:** 3 items in flight, assert flush with in_valid=1 and in_data=8'h30 → in_ready=0 and out_valid=0 during the flush cycle. After the edge, count=0 and out_data=8'hA5. 8'h30 never emerges.
- **Reset vs. flush:** assert rst_n=0 and flush=1 on the same edge with 2 items in flight → state equals reset values. A new item 8'h40 sent afterwards appears after 3 edges.

Source files
------------

// File: rtl/dff_pipe.sv
// dff_pipe: WIDTH-bit, DEPTH-stage elastic register pipeline.
// Valid/ready on both sides, bubbles collapse toward the output,
// synchronous flush, and a registered occupancy count.
module dff_pipe #(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int CW = $clog2(DEPTH+1);

    logic [DEPTH-1:0] v;           // per-stage valid bits, stage 0 is the input side
    logic [DEPTH-1:0] v_next;
    logic [DEPTH-1:0] mv;          // stage i hands its content forward (or out) this cycle
    logic [WIDTH-1:0] d [DEPTH];   // per-stage data registers
    logic             take0;       // stage 0 can take new content
    logic             accept;
    logic [CW-1:0]    count_next;

    // Move chain, walked from the output back to the input: a stage moves
    // when it is valid and the stage after it can take.
    always_comb begin
        logic t;
        logic m;
        // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
        mv    = '0;
        t     = out_ready;
        m     = 1'b0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            m     = v[i] & t;
            mv[i] = m;
            t     = !v[i] | m;
        end
        take0 = t;
    end

    assign in_ready  = !flush & take0;
    assign accept    = in_valid & in_ready;
    assign out_valid = v[DEPTH-1] & !flush;
    assign out_data  = d[DEPTH-1];

    // Next valid bits: load from upstream, else clear when content leaves, else hold.
    always_comb begin
        v_next    = v;
        v_next[0] = accept | (v[0] & !mv[0]);
        for (int i = 1; i < DEPTH; i++) begin
            v_next[i] = mv[i-1] | (v[i] & !mv[i]);
        end
    end

    // Occupancy after this edge, registered alongside the valid bits.
    always_comb begin
        count_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count_next = count_next + CW'(v_next[i]);
        end
    end

    // Stage registers: reset and flush both return every stage to idle.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            v     <= '0;
            count <= '0;
            // NOTE: the data registers are reset as well, because out_data must read RESET_VAL after reset or flush.
            for (int i = 0; i < DEPTH; i++) begin
                d[i] <= RESET_VAL;
            end
        end else begin
            // NOTE: non-blocking assignments make every stage read its neighbour's pre-edge value, giving a true shift rather than a ripple-through.
            v     <= v_next;
            count <= count_next;
            if (accept) begin
                d[0] <= in_data;
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (mv[i-1]) begin
                    d[i] <= d[i-1];
                end
            end
        end
    end

endmodule
